// File: rtl/branch_resolver.sv
// EX-stage branch resolution: compares the carried prediction with the actual next PC,
// redirects/flushes on a mispredict, squashes wrong-path resolutions and trains the predictor.
module branch_resolver #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ex_valid_i,
   input  logic             ex_stall_i,
   input  logic [31:0]      ex_pc_i,
   input  logic [31:0]      ex_pred_pc_i,
   input  logic             ex_is_br_i,
   input  logic             ex_taken_i,
   input  logic [31:0]      ex_target_i,
   output logic             redirect_o,
   output logic [31:0]      redirect_pc_o,
   output logic             flush_o,
   output logic             fb_valid_o,
   output logic [31:0]      insn_pc_o,
   output logic             insn_is_br_o,
   output logic [31:0]      insn_target_o,
   output logic [CNT_W-1:0] br_count_o,
   output logic [CNT_W-1:0] mispred_count_o
);

   // state  | meaning
   // IDLE   | EX resolutions are accepted
   // SQUASH | wrong-path window after a redirect; EX inputs ignored

   typedef enum logic {IDLE, SQUASH} state_t;

   localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

   state_t      state, state_nxt;
   logic [2:0]  sq_cnt, sq_cnt_nxt;
   logic        resolve, mispred, fb, br_inc;
   logic [31:0] actual_npc;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state  <= IDLE;
         sq_cnt <= 3'd0;
      end else begin
         state  <= state_nxt;
         sq_cnt <= sq_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      sq_cnt_nxt = sq_cnt;
      case (state)
         IDLE: begin
            if (mispred) begin
               state_nxt  = SQUASH;
               sq_cnt_nxt = FLUSH_LD;
            end
         end
         SQUASH: begin
            if (!ex_stall_i) begin
               sq_cnt_nxt = sq_cnt - 3'd1;
               if (sq_cnt == 3'd1) state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt  = IDLE;
            sq_cnt_nxt = 3'd0;
         end
      endcase
   end

   always_comb begin
      resolve    = (state == IDLE) && ex_valid_i && !ex_stall_i;
      actual_npc = (ex_is_br_i && ex_taken_i) ? ex_target_i : ex_pc_i + 32'd4;
      mispred    = resolve && (actual_npc != ex_pred_pc_i);
      fb         = resolve && (ex_is_br_i || mispred);
      br_inc     = resolve && ex_is_br_i;
   end

   // Registered outputs; payloads hold their last value between pulses.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         redirect_o      <= 1'b0;
         flush_o         <= 1'b0;
         redirect_pc_o   <= 32'd0;
         fb_valid_o      <= 1'b0;
         insn_pc_o       <= 32'd0;
         insn_is_br_o    <= 1'b0;
         insn_target_o   <= 32'd0;
         br_count_o      <= '0;
         mispred_count_o <= '0;
      end else begin
         redirect_o <= mispred;
         flush_o    <= mispred;
         fb_valid_o <= fb;
         if (mispred) redirect_pc_o <= actual_npc;
         if (fb) begin
            insn_pc_o     <= ex_pc_i;
            insn_is_br_o  <= ex_is_br_i && ex_taken_i;
            insn_target_o <= ex_target_i;
         end
         if (br_inc && (br_count_o != {CNT_W{1'b1}}))
            br_count_o <= br_count_o + CNT_W'(1);
         if (mispred && (mispred_count_o != {CNT_W{1'b1}}))
            mispred_count_o <= mispred_count_o + CNT_W'(1);
      end
   end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

EX-stage branch resolution unit: the consumer of `pc_pred_o` and the producer of the predictor's EX feedback. It compares the next PC predicted at fetch, carried down the pipe, against the actual next PC computed in EX. On a mismatch it issues a one-cycle redirect/flush to IF/ID, then squashes wrong-path resolutions for a fixed window. It also drives the training feedback bus back to `branch_predictor` and keeps branch and mispredict counters.

## Interface
- `FLUSH_CYCLES`, default 2: non-stalled cycles after a redirect during which EX resolutions are ignored; legal range 1-7.
- `CNT_W`, default 32: width of the performance counters.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `ex_valid_i`  in  1  EX holds a valid instruction.
- `ex_stall_i`  in  1  EX is held this cycle; no resolution occurs.
- `ex_pc_i`  in  32  PC of the EX instruction.
- `ex_pred_pc_i`  in  32  next PC predicted at fetch for this instruction.
- `ex_is_br_i`  in  1  instruction is a control transfer (branch, jal, jalr).
- `ex_taken_i`  in  1  control transfer is taken; ignored when `ex_is_br_i`=0.
- `ex_target_i`  in  32  computed target.
- `redirect_o`  out  1  one-cycle pulse: IF loads `redirect_pc_o`.
- `redirect_pc_o`  out  32  corrected next PC.
- `flush_o`  out  1  one-cycle pulse, coincident with `redirect_o`: squash IF/ID.
- `fb_valid_o`  out  1  feedback valid pulse.
- `insn_pc_o`  out  32  feeds predictor `insn_pc_i`.
- `insn_is_br_o`  out  1  feeds predictor `insn_is_br_i`; 1 only for a taken branch.
- `insn_target_o`  out  32  feeds predictor `insn_target_i`.
- `br_count_o`  out  CNT_W  resolved control transfers.
- `mispred_count_o`  out  CNT_W  mispredictions.

## Operation
- Resolution occurs in cycles where `ex_valid_i`=1, `ex_stall_i`=0 and the state is IDLE. Each instruction resolves exactly once.
- Actual next PC: `ex_target_i` if `ex_is_br_i` and `ex_taken_i`; otherwise `ex_pc_i`+4, computed mod 2^32 so 0xFFFFFFFC wraps to 0.
- Mispredict: actual next PC differs from `ex_pred_pc_i`. This applies to non-branches too, because predictor aliasing can produce it.
- Feedback is sent when the resolved instruction is a branch or a mispredict:
  - `insn_pc_o` = `ex_pc_i`.
  - `insn_is_br_o` = `ex_is_br_i` & `ex_taken_i`.
  - `insn_target_o` = `ex_target_i`.
- `br_count_o` increments per resolved `ex_is_br_i`=1. `mispred_count_o` increments per mispredict. Both saturate at all-ones and never wrap.
- FSM:
  - IDLE: a mispredict moves to SQUASH and loads the squash counter with FLUSH_CYCLES.
  - SQUASH: all EX inputs are ignored; no feedback, no counter updates, no redirect.
  - In SQUASH, the squash counter decrements on each cycle with `ex_stall_i`=0 and holds on stalled cycles.
  - Decrementing from 1 returns the FSM to IDLE at that edge.
- Reset (any time, including mid-SQUASH): state IDLE, squash counter 0. `redirect_o`, `flush_o`, `fb_valid_o`, `insn_is_br_o` = 0. `redirect_pc_o`, `insn_pc_o`, `insn_target_o`, and both counters = 0.

## Timing
- All outputs are registered. Latency is 1 cycle: a resolution at edge N is visible after edge N+1.
- `redirect_o`, `flush_o` and `fb_valid_o` are single-cycle pulses. They never assert on consecutive cycles from separate resolutions, because SQUASH covers at least 1 cycle after every redirect.
- `redirect_pc_o` and the `insn_*_o` outputs hold their last value when not pulsing.
- Example, mispredict resolved in cycle N, FLUSH_CYCLES=2, no stalls:
  - Cycle N+1: `redirect_o`=1, `flush_o`=1.
  - Cycles N+1 and N+2: EX inputs ignored.
  - Cycle N+3: EX resolves normally again.
- A stall in EX during SQUASH extends the window cycle for cycle.
- A mispredict in the final SQUASH cycle is ignored.
- A non-mispredicting non-branch produces no pulse and no counter change.

## Test plan
- Reset then idle → every output 0. Assert `rst_i` mid-SQUASH → outputs 0 immediately (asynchronously), and the first resolution after release is honoured.
- Correct prediction: pc=0x100, is_br=1, taken=1, target=0x200, pred=0x200 → `fb_valid_o`=1 with insn_pc=0x100, insn_is_br=1, insn_target=0x200; `redirect_o`=0; `br_count_o`=1; `mispred_count_o`=0.
- Not-taken mispredict: pc=0x40, is_br=1, taken=0, pred=0x80 → next cycle `redirect_o`=`flush_o`=1, `redirect_pc_o`=0x44, `insn_is_br_o`=0. A second mispredict presented in the next 2 cycles → ignored. At N+3 a resolution is accepted.
- Taken mispredict under static pc+4 prediction: pc=0x1000, taken, target=0x0F00, pred=0x1004 → `redirect_pc_o`=0x0F00; `mispred_count_o`=1. Hold `ex_stall_i`=1 for 3 cycles inside SQUASH → window lasts 5 cycles.
- Aliased non-branch: pc=0xFFFFFFFC, is_br=0, pred=0x8 → `redirect_pc_o`=0x0, `fb_valid_o`=1 with `insn_is_br_o`=0, `br_count_o` unchanged.
- Saturation with CNT_W=4: 20 back-to-back correctly predicted branches → `br_count_o` stops at 0xF; stalled cycles never double-count.
